// File: rtl/jet_pkg.sv
// Shared types and constants for the L2 jet-builder phi-bin datapath.
package jet_pkg;
    localparam int PT_W   = 9;
    localparam int NT_W   = 5;
    localparam int NX_W   = 4;
    localparam int PHI_W  = 5;
    localparam int NPHI   = 27;
    localparam int BIN3_W = 54;

    typedef struct packed {
        logic [PT_W-1:0] pt;
        logic [NT_W-1:0] nt;
        logic [NX_W-1:0] nx;
    } phibin_t;

    typedef struct packed {
        phibin_t l;
        phibin_t c;
        phibin_t r;
    } bin3_t;

    typedef enum logic {
        W_FILL = 1'b0,
        W_HOLD = 1'b1
    } wstate_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_SERVE = 2'd2
    } sstate_e;

    function automatic logic phi_in_range(input logic [PHI_W-1:0] phi);
        return phi < PHI_W'(NPHI);
    endfunction
endpackage

// File: rtl/jet_phibin_server_if.sv
// Fill (from L1 clustering) and fetch (from build_jet) signals of the phi-bin server.
interface jet_phibin_server_if;
    import jet_pkg::*;

    logic             wr_en;
    logic [PHI_W-1:0] wr_phi;
    logic [PT_W-1:0]  wr_pt_l, wr_pt_c, wr_pt_r;
    logic [NT_W-1:0]  wr_nt_l, wr_nt_c, wr_nt_r;
    logic [NX_W-1:0]  wr_nx_l, wr_nx_c, wr_nx_r;
    logic             wr_last;
    logic             wr_ready;
    logic             start;
    logic [PHI_W-1:0] addr;
    logic             done;
    logic [PT_W-1:0]  Center, Left, Right;
    logic [NT_W-1:0]  my_ntrx, left_ntrx, right_ntrx;
    logic [NX_W-1:0]  my_xcnt, left_xcnt, right_xcnt;
    logic             ovf_err;

    modport server (
        input  wr_en, wr_phi, wr_pt_l, wr_pt_c, wr_pt_r, wr_nt_l, wr_nt_c, wr_nt_r,
               wr_nx_l, wr_nx_c, wr_nx_r, wr_last, addr, done,
        output wr_ready, start, Center, Left, Right, my_ntrx, left_ntrx, right_ntrx,
               my_xcnt, left_xcnt, right_xcnt, ovf_err
    );

    modport client (
        output wr_en, wr_phi, wr_pt_l, wr_pt_c, wr_pt_r, wr_nt_l, wr_nt_c, wr_nt_r,
               wr_nx_l, wr_nx_c, wr_nx_r, wr_last, addr, done,
        input  wr_ready, start, Center, Left, Right, my_ntrx, left_ntrx, right_ntrx,
               my_xcnt, left_xcnt, right_xcnt, ovf_err
    );
endinterface

// File: rtl/jet_phibin_bank.sv
// One event bank: NPHI three-column bins with per-bin valid bits and a registered,
// zero-substituting read port.
module jet_phibin_bank
    import jet_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clear_all,
    input  logic             wr_en,
    input  logic [PHI_W-1:0] wr_phi,
    input  bin3_t            wr_data,
    input  logic             rd_en,
    input  logic [PHI_W-1:0] rd_addr,
    output bin3_t            rd_data
);
    bin3_t           mem_q [NPHI];
    logic [NPHI-1:0] valid_q, valid_d;
    bin3_t           rd_data_q, rd_data_d;
    logic            wr_hit_s, rd_hit_s;

    assign wr_hit_s = wr_en && phi_in_range(wr_phi);
    assign rd_hit_s = rd_en && phi_in_range(rd_addr) && valid_q[rd_addr];

    // Valid-bit update: bulk clear when the bank is recycled as fill bank.
    always_comb begin
        valid_d = valid_q;
        if (clear_all) begin
            valid_d = '0;
        end else if (wr_hit_s) begin
            valid_d[wr_phi] = 1'b1;
        end else begin
            valid_d = valid_q;
        end
    end

    // Read mux: empty, out-of-range or unserved reads return zero.
    always_comb begin
        rd_data_d = '0;
        if (rd_hit_s) begin
            rd_data_d = mem_q[rd_addr];
        end else begin
            rd_data_d = '0;
        end
    end

    // Control and read-data registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q   <= '0;
            rd_data_q <= '0;
        end else begin
            valid_q   <= valid_d;
            rd_data_q <= rd_data_d;
        end
    end

    // Storage array; contents are meaningless without the valid bit, so no reset.
    always_ff @(posedge clk) begin
        if (wr_hit_s) begin
            mem_q[wr_phi] <= wr_data;
        end
    end

    assign rd_data = rd_data_q;
endmodule

// File: rtl/jet_phibin_server.sv
// Double-buffered phi-bin server: one bank fills from L1 while the other answers
// build_jet fetches with a fixed 2-cycle latency.
module jet_phibin_server
    import jet_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    jet_phibin_server_if.server  bus
);
    wstate_e          wstate_q, wstate_d;
    sstate_e          sstate_q, sstate_d;
    logic             fill_sel_q, fill_sel_d;
    logic             start_q, start_d;
    logic             wr_ready_q, wr_ready_d;
    logic             ovf_err_q, ovf_err_d;
    logic [PHI_W-1:0] addr_q, addr_d;
    logic             wr_acc_s, last_acc_s, serving_s, release_s, swap_s;
    bin3_t            wr_word_s, rd0_s, rd1_s, rd_s;

    assign wr_word_s = {bus.wr_pt_l, bus.wr_nt_l, bus.wr_nx_l,
                        bus.wr_pt_c, bus.wr_nt_c, bus.wr_nx_c,
                        bus.wr_pt_r, bus.wr_nt_r, bus.wr_nx_r};

    // Handshake decode; a release in the same cycle frees the serve slot for the swap.
    always_comb begin
        wr_acc_s   = bus.wr_en && wr_ready_q;
        last_acc_s = wr_acc_s && bus.wr_last;
        serving_s  = (sstate_q != S_IDLE);
        release_s  = (sstate_q == S_SERVE) && bus.done;
        if (wstate_q == W_FILL) begin
            swap_s = last_acc_s && (!serving_s || release_s);
        end else begin
            swap_s = release_s;
        end
    end

    // Next-state logic for the fill and serve FSMs.
    always_comb begin
        wstate_d = wstate_q;
        case (wstate_q)
            W_FILL:  if (last_acc_s && !swap_s) wstate_d = W_HOLD; else wstate_d = W_FILL;
            W_HOLD:  if (release_s) wstate_d = W_FILL; else wstate_d = W_HOLD;
            default: wstate_d = W_FILL;
        endcase
        sstate_d = sstate_q;
        if (swap_s) begin
            sstate_d = S_START;
        end else begin
            case (sstate_q)
                S_IDLE:  sstate_d = S_IDLE;
                S_START: sstate_d = S_SERVE;
                S_SERVE: if (bus.done) sstate_d = S_IDLE; else sstate_d = S_SERVE;
                default: sstate_d = S_IDLE;
            endcase
        end
        fill_sel_d = swap_s ? ~fill_sel_q : fill_sel_q;
        start_d    = (sstate_d == S_START);
        wr_ready_d = (wstate_d == W_FILL);
        ovf_err_d  = ovf_err_q || (bus.wr_en && !wr_ready_q);
        addr_d     = bus.addr;
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wstate_q   <= W_FILL;
            sstate_q   <= S_IDLE;
            fill_sel_q <= 1'b0;
            start_q    <= 1'b0;
            wr_ready_q <= 1'b1;
            ovf_err_q  <= 1'b0;
            addr_q     <= '0;
        end else begin
            wstate_q   <= wstate_d;
            sstate_q   <= sstate_d;
            fill_sel_q <= fill_sel_d;
            start_q    <= start_d;
            wr_ready_q <= wr_ready_d;
            ovf_err_q  <= ovf_err_d;
            addr_q     <= addr_d;
        end
    end

    // The serve bank is always the one not being filled; it is cleared when recycled.
    jet_phibin_bank u_bank0 (
        .clk       (clk),
        .reset     (reset),
        .clear_all (swap_s && fill_sel_q),
        .wr_en     (wr_acc_s && !fill_sel_q),
        .wr_phi    (bus.wr_phi),
        .wr_data   (wr_word_s),
        .rd_en     (serving_s && fill_sel_q),
        .rd_addr   (addr_q),
        .rd_data   (rd0_s)
    );

    jet_phibin_bank u_bank1 (
        .clk       (clk),
        .reset     (reset),
        .clear_all (swap_s && !fill_sel_q),
        .wr_en     (wr_acc_s && fill_sel_q),
        .wr_phi    (bus.wr_phi),
        .wr_data   (wr_word_s),
        .rd_en     (serving_s && !fill_sel_q),
        .rd_addr   (addr_q),
        .rd_data   (rd1_s)
    );

    // Only one bank is read-enabled per cycle, so the other read register is zero.
    assign rd_s           = rd0_s | rd1_s;
    assign bus.Left       = rd_s.l.pt;
    assign bus.left_ntrx  = rd_s.l.nt;
    assign bus.left_xcnt  = rd_s.l.nx;
    assign bus.Center     = rd_s.c.pt;
    assign bus.my_ntrx    = rd_s.c.nt;
    assign bus.my_xcnt    = rd_s.c.nx;
    assign bus.Right      = rd_s.r.pt;
    assign bus.right_ntrx = rd_s.r.nt;
    assign bus.right_xcnt = rd_s.r.nx;
    assign bus.start      = start_q;
    assign bus.wr_ready   = wr_ready_q;
    assign bus.ovf_err    = ovf_err_q;
endmodule

// File: tb/tb_jet_phibin_server.sv
// Directed bench for jet_phibin_server: fill/serve handshake, latency, overflow and reset.
module tb_jet_phibin_server;
    import jet_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    logic [53:0] g1 [NPHI];
    logic [53:0] g2 [NPHI];

    jet_phibin_server_if bus();
    jet_phibin_server dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic [53:0] outs();
        return {bus.Left, bus.left_ntrx, bus.left_xcnt, bus.Center, bus.my_ntrx, bus.my_xcnt,
                bus.Right, bus.right_ntrx, bus.right_xcnt};
    endfunction

    function automatic logic [53:0] pat(input int base, input int p);
        return {9'(base + p + 100), 5'(p), 4'(p + 3),
                9'(base + p + 1), 5'(p + 1), 4'(p),
                9'(base + 2 * p), 5'(31 - p), 4'(15 - p)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_bin(input int phi, input logic [53:0] w, input logic last, input logic dn);
        bus.wr_en = 1'b1;
        bus.wr_phi = 5'(phi);
        {bus.wr_pt_l, bus.wr_nt_l, bus.wr_nx_l, bus.wr_pt_c, bus.wr_nt_c, bus.wr_nx_c,
         bus.wr_pt_r, bus.wr_nt_r, bus.wr_nx_r} = w;
        bus.wr_last = last;
        bus.done = dn;
        tick();
        bus.wr_en = 1'b0;
        bus.wr_last = 1'b0;
        bus.done = 1'b0;
    endtask

    task automatic wr_event(input int base, input logic dn_on_last);
        for (int p = 0; p < NPHI; p++)
            wr_bin(p, pat(base, p), p == NPHI - 1, dn_on_last && (p == NPHI - 1));
    endtask

    task automatic rd_bin(input int a, output logic [53:0] v);
        bus.addr = 5'(a);
        @(posedge clk);
        tick();
        v = outs();
    endtask

    task automatic pulse_done();
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        checks++; if (bus.start !== 1'b0) begin errors++; $display("FAIL reset_start: got %b expected 0", bus.start); end
        checks++; if (bus.wr_ready !== 1'b1) begin errors++; $display("FAIL reset_wr_ready: got %b expected 1", bus.wr_ready); end
        checks++; if (bus.ovf_err !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", bus.ovf_err); end
        checks++; if (outs() !== 54'd0) begin errors++; $display("FAIL reset_data: got %h expected 0", outs()); end
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_full_event();
        logic [53:0] v;
        wr_event(0, 1'b0);
        checks++; if (bus.start !== 1'b1) begin errors++; $display("FAIL full_start: got %b expected 1", bus.start); end
        checks++; if (bus.wr_ready !== 1'b1) begin errors++; $display("FAIL full_wr_ready: got %b expected 1", bus.wr_ready); end
        tick();
        checks++; if (bus.start !== 1'b0) begin errors++; $display("FAIL full_start_pulse: got %b expected 0", bus.start); end
        rd_bin(5, v);
        checks++; if (bus.Center !== 9'd6) begin errors++; $display("FAIL full_center5: got %0d expected 6", bus.Center); end
        checks++; if (v !== pat(0, 5)) begin errors++; $display("FAIL full_addr5: got %h expected %h", v, pat(0, 5)); end
        rd_bin(26, v);
        checks++; if (v !== pat(0, 26)) begin errors++; $display("FAIL full_addr26: got %h expected %h", v, pat(0, 26)); end
        rd_bin(27, v);
        checks++; if (v !== 54'd0) begin errors++; $display("FAIL full_addr27: got %h expected 0", v); end
        pulse_done();
        rd_bin(5, v);
        checks++; if (v !== 54'd0) begin errors++; $display("FAIL full_no_serve: got %h expected 0", v); end
    endtask

    task automatic test_single_phi();
        logic [53:0] v, w3, ex;
        w3 = {9'd0, 5'd0, 4'd0, 9'd100, 5'd4, 4'd2, 9'd0, 5'd0, 4'd0};
        wr_bin(3, w3, 1'b1, 1'b0);
        checks++; if (bus.start !== 1'b1) begin errors++; $display("FAIL single_start: got %b expected 1", bus.start); end
        tick();
        for (int a = 0; a < 32; a++) begin
            rd_bin(a, v);
            ex = (a == 3) ? w3 : 54'd0;
            checks++; if (v !== ex) begin errors++; $display("FAIL single_addr%0d: got %h expected %h", a, v, ex); end
        end
        pulse_done();
    endtask

    task automatic test_back_to_back();
        logic [53:0] v;
        wr_event(20, 1'b0);
        checks++; if (bus.start !== 1'b1) begin errors++; $display("FAIL b2b_start_a: got %b expected 1", bus.start); end
        tick();
        wr_event(50, 1'b0);
        checks++; if (bus.wr_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_low: got %b expected 0", bus.wr_ready); end
        checks++; if (bus.start !== 1'b0) begin errors++; $display("FAIL b2b_no_start: got %b expected 0", bus.start); end
        wr_bin(7, '1, 1'b0, 1'b0);
        checks++; if (bus.ovf_err !== 1'b1) begin errors++; $display("FAIL b2b_ovf: got %b expected 1", bus.ovf_err); end
        rd_bin(5, v);
        checks++; if (v !== pat(20, 5)) begin errors++; $display("FAIL b2b_still_a: got %h expected %h", v, pat(20, 5)); end
        pulse_done();
        checks++; if (bus.start !== 1'b1) begin errors++; $display("FAIL b2b_start_b: got %b expected 1", bus.start); end
        checks++; if (bus.wr_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_high: got %b expected 1", bus.wr_ready); end
        tick();
        checks++; if (bus.start !== 1'b0) begin errors++; $display("FAIL b2b_start_b_pulse: got %b expected 0", bus.start); end
        rd_bin(5, v);
        checks++; if (v !== pat(50, 5)) begin errors++; $display("FAIL b2b_b_addr5: got %h expected %h", v, pat(50, 5)); end
        rd_bin(7, v);
        checks++; if (v !== pat(50, 7)) begin errors++; $display("FAIL b2b_dropped_write: got %h expected %h", v, pat(50, 7)); end
        pulse_done();
    endtask

    task automatic test_done_with_last();
        logic [53:0] v;
        wr_event(70, 1'b0);
        tick();
        wr_event(90, 1'b1);
        checks++; if (bus.start !== 1'b1) begin errors++; $display("FAIL dwl_start: got %b expected 1", bus.start); end
        checks++; if (bus.wr_ready !== 1'b1) begin errors++; $display("FAIL dwl_ready: got %b expected 1", bus.wr_ready); end
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++; if (bus.start !== 1'b0) begin errors++; $display("FAIL dwl_single_pulse%0d: got %b expected 0", k, bus.start); end
        end
        rd_bin(5, v);
        checks++; if (v !== pat(90, 5)) begin errors++; $display("FAIL dwl_data: got %h expected %h", v, pat(90, 5)); end
        pulse_done();
    endtask

    task automatic test_reset_mid_serve();
        logic [53:0] v;
        wr_event(110, 1'b0);
        tick();
        bus.addr = 5'd10;
        tick();
        tick();
        checks++; if (outs() !== pat(110, 10)) begin errors++; $display("FAIL rst_pre: got %h expected %h", outs(), pat(110, 10)); end
        reset = 1'b1;
        #1;
        checks++; if (outs() !== 54'd0) begin errors++; $display("FAIL rst_data: got %h expected 0", outs()); end
        checks++; if (bus.start !== 1'b0) begin errors++; $display("FAIL rst_start: got %b expected 0", bus.start); end
        checks++; if (bus.wr_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b expected 1", bus.wr_ready); end
        checks++; if (bus.ovf_err !== 1'b0) begin errors++; $display("FAIL rst_ovf: got %b expected 0", bus.ovf_err); end
        tick();
        reset = 1'b0;
        tick();
        rd_bin(10, v);
        checks++; if (v !== 54'd0) begin errors++; $display("FAIL rst_after: got %h expected 0", v); end
        wr_bin(0, pat(200, 0), 1'b1, 1'b0);
        checks++; if (bus.start !== 1'b1) begin errors++; $display("FAIL rst_new_start: got %b expected 1", bus.start); end
        tick();
        rd_bin(10, v);
        checks++; if (v !== 54'd0) begin errors++; $display("FAIL rst_stale: got %h expected 0", v); end
        rd_bin(0, v);
        checks++; if (v !== pat(200, 0)) begin errors++; $display("FAIL rst_new_data: got %h expected %h", v, pat(200, 0)); end
        pulse_done();
    endtask

    task automatic test_builder_sweep();
        logic [63:0] r;
        logic [53:0] ex;
        logic        ex_start;
        int          d;
        for (int p = 0; p < NPHI; p++) begin
            r = {$urandom(), $urandom()};
            g1[p] = r[53:0];
            r = {$urandom(), $urandom()};
            g2[p] = r[53:0];
        end
        for (int p = 0; p < NPHI; p++) wr_bin(p, g1[p], p == NPHI - 1, 1'b0);
        checks++; if (bus.start !== 1'b1) begin errors++; $display("FAIL sweep_start: got %b expected 1", bus.start); end
        for (int p = 0; p < NPHI; p++) wr_bin(p, g2[p], p == NPHI - 1, 1'b0);
        checks++; if (bus.wr_ready !== 1'b0) begin errors++; $display("FAIL sweep_hold: got %b expected 0", bus.wr_ready); end
        for (int ev = 0; ev < 2; ev++) begin
            for (int i = 0; i <= NPHI; i++) begin
                if (i < NPHI) bus.addr = 5'(i);
                tick();
                if (i >= 1) begin
                    ex = (ev == 0) ? g1[i-1] : g2[i-1];
                    checks++; if (outs() !== ex) begin errors++; $display("FAIL sweep_ev%0d_addr%0d: got %h expected %h", ev, i - 1, outs(), ex); end
                end
            end
            d = $urandom_range(0, 5);
            for (int k = 0; k < d; k++) begin
                tick();
                checks++; if (bus.start !== 1'b0) begin errors++; $display("FAIL sweep_ev%0d_wait_start: got %b expected 0", ev, bus.start); end
            end
            pulse_done();
            ex_start = (ev == 0);
            checks++; if (bus.start !== ex_start) begin errors++; $display("FAIL sweep_ev%0d_after_done: got %b expected %b", ev, bus.start, ex_start); end
            tick();
        end
        checks++; if (bus.wr_ready !== 1'b1) begin errors++; $display("FAIL sweep_end_ready: got %b expected 1", bus.wr_ready); end
    endtask

    initial begin
        reset = 1'b1;
        bus.wr_en = 1'b0;
        bus.wr_phi = 5'd0;
        {bus.wr_pt_l, bus.wr_nt_l, bus.wr_nx_l, bus.wr_pt_c, bus.wr_nt_c, bus.wr_nx_c,
         bus.wr_pt_r, bus.wr_nt_r, bus.wr_nx_r} = 54'd0;
        bus.wr_last = 1'b0;
        bus.addr = 5'd0;
        bus.done = 1'b0;
        test_reset();
        test_full_event();
        test_single_phi();
        test_back_to_back();
        test_done_with_last();
        test_reset_mid_serve();
        test_builder_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
